// File: rtl/hdmi_rd_timing_gen.sv
// hdmi_rd_timing_gen: pixel-clock raster timing generator at the read end of
// the prefetch FIFO. Pops pixels during active video, emits hs/vs/de with the
// pixel data aligned to de (one-cycle registered latency), and flags FIFO
// underflow with a sticky bit.
//
// Optional feature macro: HDMI_RD_UNDERFLOW_CNT_EN adds a 16-bit saturating
// count of underflowed pixels on output underflow_cnt.
//
// state  | meaning
// IDLE   | stopped, counters held at 0,0; waits for en & rd_vld
// RUN    | generating frames back to back while en is high
// LAST   | en dropped; finishing the current frame, then back to IDLE
module hdmi_rd_timing_gen #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    H_ACTIVE   = 1920,
  parameter int                    H_FP       = 88,
  parameter int                    H_SYNC     = 44,
  parameter int                    H_BP       = 148,
  parameter int                    V_ACTIVE   = 1080,
  parameter int                    V_FP       = 4,
  parameter int                    V_SYNC     = 5,
  parameter int                    V_BP       = 36,
  parameter logic                  HS_POL     = 1'b1,
  parameter logic                  VS_POL     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_COLOR = DATA_WIDTH'(24'h000000),
  parameter int                    CNT_W      = 12
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_vld,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_de,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  frame_start,
  output logic                  underflow,
  output logic                  busy
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries as counter-width constants; sync end is inclusive so it never
  // wraps even when the back porch is zero.
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_END_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_END_C = CNT_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        h_q, h_d;
  logic [CNT_W-1:0]        v_q, v_d;
  logic                    start;
  logic                    running;
  logic                    eol, eof;
  logic                    due;
  logic                    h_sync, v_sync;

  logic                    de_q, de_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    hs_q, hs_d;
  logic                    vs_q, vs_d;
  logic                    fs_q, fs_d;
  logic                    uf_q, uf_d;

  assign running = (state_q != S_IDLE);
  assign eol     = (h_q == H_END_C);
  assign eof     = eol && (v_q == V_END_C);
  // Pop decision uses registered state only; rd_vld never feeds rd_en.
  assign due     = running && (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign h_sync  = (h_q >= H_SS_C) && (h_q <= H_SE_C);
  assign v_sync  = (v_q >= V_SS_C) && (v_q <= V_SE_C);

  // Next-state and raster counter advance.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en && rd_vld) begin
          state_d = S_RUN;
          start   = 1'b1;
        end
      end
      S_RUN: begin
        if (!en) state_d = eof ? S_IDLE : S_LAST;
      end
      S_LAST: begin
        if (en)       state_d = S_RUN;
        else if (eof) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (running) begin
      if (eol) begin
        h_d = '0;
        v_d = eof ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Registered video outputs for the current counter position.
  always_comb begin
    de_d   = due;
    data_d = '0;
    if (due) data_d = rd_vld ? rd_data : FILL_COLOR;
    hs_d   = (running && h_sync) ? HS_POL : ~HS_POL;
    vs_d   = (running && v_sync) ? VS_POL : ~VS_POL;
    fs_d   = running && (h_q == '0) && (v_q == '0);
    uf_d   = uf_q;
    if (start)             uf_d = 1'b0;
    else if (due && !rd_vld) uf_d = 1'b1;
  end

  // State, counters and output registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      data_q  <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      data_q  <= data_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign rd_en       = due;
  assign busy        = running;
  assign vid_de      = de_q;
  assign vid_data    = data_q;
  assign vid_hs      = hs_q;
  assign vid_vs      = vs_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

`ifdef HDMI_RD_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underflowed pixels, restarted with each run.
  always_comb begin
    ucnt_d = ucnt_q;
    if (start)                                      ucnt_d = '0;
    else if (due && !rd_vld && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Underflow counter register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_hdmi_rd_timing_gen.sv
// Bench for hdmi_rd_timing_gen on a small 8x6 raster. A FIFO model feeds the
// DUT; an independent frame-position reference model predicts every output.
module tb_hdmi_rd_timing_gen;

  localparam int          DW     = 24;
  localparam int          H_ACT  = 4, H_FP = 1, H_SY = 2, H_BP = 1;
  localparam int          V_ACT  = 3, V_FP = 1, V_SY = 1, V_BP = 1;
  localparam int          H_TOT  = H_ACT + H_FP + H_SY + H_BP;
  localparam int          V_TOT  = V_ACT + V_FP + V_SY + V_BP;
  localparam int          F_TOT  = H_TOT * V_TOT;
  localparam logic        HS_P   = 1'b1;
  localparam logic        VS_P   = 1'b1;
  localparam logic [DW-1:0] FILL = 24'hABCDEF;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          rd_en;
  logic [DW-1:0] vid_data;
  logic          vid_de, vid_hs, vid_vs, frame_start, underflow, busy;
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  int errors = 0;
  int checks = 0;

  hdmi_rd_timing_gen #(
    .DATA_WIDTH(DW), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .HS_POL(HS_P), .VS_POL(VS_P), .FILL_COLOR(FILL), .CNT_W(4)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en), .rd_data(rd_data), .rd_vld(rd_vld),
    .rd_en(rd_en), .vid_data(vid_data), .vid_de(vid_de), .vid_hs(vid_hs),
    .vid_vs(vid_vs), .frame_start(frame_start), .underflow(underflow), .busy(busy)
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // ---------------- FIFO environment (popped by the DUT) ----------------
  logic [DW-1:0] mem [0:1023];
  logic [9:0]    wp = '0;
  logic [9:0]    rp = '0;
  logic          vld_gate = 1'b1;

  assign rd_vld  = (wp != rp) && vld_gate;
  assign rd_data = mem[rp];

  always @(posedge rd_clk) begin
    if (!rd_rst && rd_en && rd_vld) rp <= rp + 10'd1;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];
  bit            m_busy = 0;
  int            m_pos = 0;
  bit            e_de = 0, e_hs = 0, e_vs = 0, e_fs = 0, m_uf = 0;
  logic [DW-1:0] e_data = '0;
  int            m_cnt = 0;
  bit            m_vld;

  function automatic bit pix_due(int p);
    return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
  endfunction

  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      m_busy = 0; m_pos = 0; e_de = 0; e_data = '0;
      e_hs = 0; e_vs = 0; e_fs = 0; m_uf = 0; m_cnt = 0;
    end else begin
      m_vld = (mq.size() != 0) && vld_gate;
      if (m_busy) begin
        e_de = pix_due(m_pos);
        if (e_de) begin
          if (m_vld) e_data = mq.pop_front();
          else begin
            e_data = FILL; m_uf = 1;
            if (m_cnt != 65535) m_cnt++;
          end
        end else e_data = '0;
        e_hs = ((m_pos % H_TOT) >= H_ACT + H_FP) && ((m_pos % H_TOT) < H_ACT + H_FP + H_SY);
        e_vs = ((m_pos / H_TOT) >= V_ACT + V_FP) && ((m_pos / H_TOT) < V_ACT + V_FP + V_SY);
        e_fs = (m_pos == 0);
        if (m_pos == F_TOT - 1 && !en) begin
          m_busy = 0; m_pos = 0;
        end else m_pos = (m_pos + 1) % F_TOT;
      end else begin
        e_de = 0; e_data = '0; e_hs = 0; e_vs = 0; e_fs = 0;
        if (en && m_vld) begin
          m_busy = 1; m_pos = 0; m_uf = 0; m_cnt = 0;
        end
      end
    end
  end

  function automatic logic [30:0] exp_vec();
    return {m_busy && pix_due(m_pos), e_de, e_hs ? HS_P : ~HS_P, e_vs ? VS_P : ~VS_P,
            e_fs, m_uf, m_busy, e_data};
  endfunction

  function automatic logic [30:0] dut_vec();
    return {rd_en, vid_de, vid_hs, vid_vs, frame_start, underflow, busy, vid_data};
  endfunction

  task automatic push(input logic [DW-1:0] v);
    mem[wp] = v;
    wp = wp + 10'd1;
    mq.push_back(v);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [30:0] rst_vec;
    rst_vec = {1'b0, 1'b0, ~HS_P, ~VS_P, 3'b000, {DW{1'b0}}};
    for (int i = 1; i <= 12; i++) push(DW'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== rst_vec) begin
        errors++; $display("FAIL reset_hold cyc %0d: got %h want %h", c, dut_vec(), rst_vec);
      end
    end
    rd_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec() || rd_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_frame();
    int de_n = 0, fs_n = 0, hs_n = 0, vs_n = 0;
    logic [DW-1:0] got[$];
    en = 1'b1;
    for (int c = 0; c < F_TOT + 4; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_frame cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (vid_de) begin de_n++; got.push_back(vid_data); end
      if (frame_start) fs_n++;
      if (vid_hs == HS_P) hs_n++;
      if (vid_vs == VS_P) vs_n++;
      en = 1'b0;
    end
    checks++;
    if (de_n != 12 || fs_n != 1 || hs_n != 12 || vs_n != 8 || underflow !== 1'b0) begin
      errors++; $display("FAIL full_frame_counts: got de=%0d fs=%0d hs=%0d vs=%0d uf=%b want 12 1 12 8 0", de_n, fs_n, hs_n, vs_n, underflow);
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== DW'(k + 1)) begin
        errors++; $display("FAIL full_frame_data idx %0d: got %h want %h", k, got[k], DW'(k + 1));
      end
    end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] src[6];
    int idx = 0;
    for (int i = 0; i < 6; i++) begin
      src[i] = DW'($urandom);
      push(src[i]);
    end
    en = 1'b1;
    for (int c = 0; c < F_TOT + 4; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL underflow cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (vid_de) begin
        idx++;
        checks++;
        if (vid_data !== ((idx <= 6) ? src[idx-1] : FILL) || underflow !== (idx >= 7)) begin
          errors++; $display("FAIL underflow_pix %0d: got data=%h uf=%b want data=%h uf=%b", idx, vid_data, underflow, (idx <= 6) ? src[idx-1] : FILL, idx >= 7);
        end
      end
      en = 1'b0;
    end
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
    checks++;
    if (underflow_cnt !== 16'd6) begin
      errors++; $display("FAIL underflow_cnt: got %0d want 6", underflow_cnt);
    end
`endif
  endtask

  task automatic test_stop();
    int busy_n = 0;
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    en = 1'b1;
    for (int c = 0; c < F_TOT + 12; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stop cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (busy) busy_n++;
      if (c == 10) en = 1'b0;
    end
    checks++;
    if (busy_n != F_TOT || busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL stop_len: got busy_cycles=%0d busy=%b rd_en=%b want %0d 0 0", busy_n, busy, rd_en, F_TOT);
    end
  endtask

  task automatic test_back_to_back();
    int fs_at[$];
    for (int i = 0; i < 24; i++) push(DW'($urandom));
    en = 1'b1;
    for (int c = 0; c < 2 * F_TOT + 12; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (frame_start) fs_at.push_back(c);
      if (c == F_TOT + 10) en = 1'b0;
    end
    checks++;
    if (fs_at.size() != 2 || underflow !== 1'b0) begin
      errors++; $display("FAIL b2b_frames: got starts=%0d uf=%b want 2 0", fs_at.size(), underflow);
    end else begin
      checks++;
      if (fs_at[1] - fs_at[0] != F_TOT) begin
        errors++; $display("FAIL b2b_gap: got %0d want %0d", fs_at[1] - fs_at[0], F_TOT);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] rst_vec;
    int fs_c = -1;
    rst_vec = {1'b0, 1'b0, ~HS_P, ~VS_P, 3'b000, {DW{1'b0}}};
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_pre cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    rd_rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== rst_vec) begin
      errors++; $display("FAIL rst_mid_async: got %h want %h", dut_vec(), rst_vec);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec() || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_idle cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    en = 1'b1;
    for (int c = 0; c < F_TOT + 4; c++) begin
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rst_mid_restart cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (frame_start && fs_c < 0) fs_c = c;
      en = 1'b0;
    end
    checks++;
    if (fs_c != 1) begin
      errors++; $display("FAIL rst_mid_fs: got first frame_start at %0d want 1", fs_c);
    end
  endtask

  task automatic test_random_gaps();
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    en = 1'b1;
    for (int c = 0; c < F_TOT + 20; c++) begin
      vld_gate = ($urandom_range(0, 3) != 0);
      @(negedge rd_clk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_gaps cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
`ifdef HDMI_RD_UNDERFLOW_CNT_EN
      checks++;
      if (underflow_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_gaps_cnt cyc %0d: got %0d want %0d", c, underflow_cnt, m_cnt);
      end
`endif
      if (c == 6) en = 1'b0;
    end
    vld_gate = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_underflow();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
